// File: rtl/temporizador.sv
// Cooking countdown timer: BCD mm:ss value entered from the keypad while the
// oven is idle, counted down once per prescaled tick while the magnetron is on.
// timer_done feeds the start/stop control logic downstream.
//
// Interface behaviour, in one place:
//   load    - single-cycle strobe, sampled on every rising edge. Accepted only
//             when enable=0, clearn=1 and digit<=9; otherwise dropped silently.
//   clearn  - level-sensitive, synchronous; beats any decrement or load.
//   enable  - level; while high and the value is nonzero the prescaler runs.
//   tick    - registered one-cycle pulse after each decrement edge.
//   All outputs are registered; state_dbg mirrors the FSM state register
//   (0 = ZERO, 1 = ARMED, 2 = COUNTING).
module temporizador #(
    parameter int CLK_DIV = 100,
    parameter int PRESC_W = 7
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clearn,
    input  logic       load,
    input  logic [3:0] digit,
    input  logic       enable,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       tick,
    output logic       running,
    output logic       timer_done,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_ZERO     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_COUNTING = 2'd2
    } state_t;

    state_t               r_state;
    logic [PRESC_W-1:0]   r_presc;
    logic [3:0]           r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
    logic                 r_tick, r_running, r_done;

    logic                 w_nonzero;
    logic                 w_presc_top;
    logic                 w_count_en;
    logic                 w_dec;
    logic                 w_load_ok;
    logic [PRESC_W-1:0]   w_presc_next;
    logic                 w_b0, w_b1, w_b2;
    logic [3:0]           w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic [3:0]           w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so;
    logic                 w_next_zero;
    state_t               w_state_next;

    // Next-value logic: prescaler, BCD borrow chain, keypad shift, clear priority.
    always_comb begin
        w_nonzero   = |{r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
        w_presc_top = (r_presc == PRESC_W'(CLK_DIV - 1));
        w_count_en  = clearn && enable && w_nonzero;
        w_dec       = w_count_en && w_presc_top;
        // enable=1 blocks loads, so a load can never collide with a decrement.
        w_load_ok   = clearn && !enable && load && (digit <= 4'd9);

        w_presc_next = '0;
        if (w_count_en && !w_presc_top)
            w_presc_next = r_presc + 1'b1;

        // Borrow chain; sec_tens 6..9 from keypad decrements normally, reloads 5.
        w_b0     = (r_sec_ones == 4'd0);
        w_dec_so = w_b0 ? 4'd9 : r_sec_ones - 4'd1;
        w_b1     = w_b0 && (r_sec_tens == 4'd0);
        w_dec_st = w_b0 ? ((r_sec_tens == 4'd0) ? 4'd5 : r_sec_tens - 4'd1) : r_sec_tens;
        w_b2     = w_b1 && (r_min_ones == 4'd0);
        w_dec_mo = w_b1 ? ((r_min_ones == 4'd0) ? 4'd9 : r_min_ones - 4'd1) : r_min_ones;
        // A decrement only happens from a nonzero value, so min_tens never wraps.
        w_dec_mt = w_b2 ? r_min_tens - 4'd1 : r_min_tens;

        w_nxt_mt = r_min_tens;
        w_nxt_mo = r_min_ones;
        w_nxt_st = r_sec_tens;
        w_nxt_so = r_sec_ones;
        if (!clearn) begin
            w_nxt_mt = 4'd0;
            w_nxt_mo = 4'd0;
            w_nxt_st = 4'd0;
            w_nxt_so = 4'd0;
        end else if (w_dec) begin
            w_nxt_mt = w_dec_mt;
            w_nxt_mo = w_dec_mo;
            w_nxt_st = w_dec_st;
            w_nxt_so = w_dec_so;
        end else if (w_load_ok) begin
            w_nxt_mt = r_min_ones;
            w_nxt_mo = r_sec_tens;
            w_nxt_st = r_sec_ones;
            w_nxt_so = digit;
        end

        w_next_zero = ~|{w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so};

        // State follows the next value: zero wins, otherwise enable picks run/pause.
        w_state_next = r_state;
        case (r_state)
            ST_ZERO:     if (!w_next_zero) w_state_next = enable ? ST_COUNTING : ST_ARMED;
            ST_ARMED:    if (w_next_zero) w_state_next = ST_ZERO;
                         else if (enable) w_state_next = ST_COUNTING;
            ST_COUNTING: if (w_next_zero) w_state_next = ST_ZERO;
                         else if (!enable) w_state_next = ST_ARMED;
            default:     w_state_next = ST_ZERO;
        endcase
    end

    // Datapath registers: prescaler and the four BCD digits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_presc    <= '0;
            r_min_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
        end else begin
            r_presc    <= w_presc_next;
            r_min_tens <= w_nxt_mt;
            r_min_ones <= w_nxt_mo;
            r_sec_tens <= w_nxt_st;
            r_sec_ones <= w_nxt_so;
        end
    end

    // FSM state and its registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_ZERO;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_tick    <= w_dec;
            r_running <= (w_state_next == ST_COUNTING);
            r_done    <= w_next_zero;
        end
    end

    assign min_tens   = r_min_tens;
    assign min_ones   = r_min_ones;
    assign sec_tens   = r_sec_tens;
    assign sec_ones   = r_sec_ones;
    assign tick       = r_tick;
    assign running    = r_running;
    assign timer_done = r_done;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_temporizador.sv
// Directed bench for temporizador with CLK_DIV=4: keypad entry, countdown,
// borrow chain, pause/resume, clear on the tick edge and async reset.
module tb_temporizador;

    localparam logic [1:0] S_ZERO = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;

    logic       clk;
    logic       resetn;
    logic       clearn;
    logic       load;
    logic [3:0] digit;
    logic       enable;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       tick, running, timer_done;
    logic [1:0] state_dbg;
    logic [15:0] t_now;

    int n_checks = 0;
    int n_errors = 0;

    temporizador #(.CLK_DIV(4), .PRESC_W(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clearn     (clearn),
        .load       (load),
        .digit      (digit),
        .enable     (enable),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .tick       (tick),
        .running    (running),
        .timer_done (timer_done),
        .state_dbg  (state_dbg)
    );

    assign t_now = {min_tens, min_ones, sec_tens, sec_ones};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checking task
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        digit = d;
        load  = 1'b1;
        cyc();
        load  = 1'b0;
    endtask

    task automatic clear_pulse();
        clearn = 1'b0;
        cyc();
        clearn = 1'b1;
    endtask

    initial begin
        resetn = 1'b1;
        clearn = 1'b1;
        load   = 1'b0;
        digit  = 4'd0;
        enable = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_time", t_now, 16'h0000);
        chk("rst_done", {15'd0, timer_done}, 16'd1);
        chk("rst_tick", {15'd0, tick}, 16'd0);
        chk("rst_running", {15'd0, running}, 16'd0);
        chk("rst_state", {14'd0, state_dbg}, {14'd0, S_ZERO});
        cyc();
        resetn = 1'b1;
        cyc();

        // keypad entry 1,3,0 -> 01:30
        press(4'd1);
        press(4'd3);
        press(4'd0);
        chk("key_time", t_now, 16'h0130);
        chk("key_done", {15'd0, timer_done}, 16'd0);
        chk("key_state", {14'd0, state_dbg}, {14'd0, S_ARMED});
        chk("key_running", {15'd0, running}, 16'd0);

        // invalid digit ignored
        press(4'd12);
        chk("bad_digit", t_now, 16'h0130);

        // clear, then a zero key keeps ZERO
        clear_pulse();
        chk("clr_time", t_now, 16'h0000);
        chk("clr_done", {15'd0, timer_done}, 16'd1);
        chk("clr_state", {14'd0, state_dbg}, {14'd0, S_ZERO});
        press(4'd0);
        chk("zero_key_state", {14'd0, state_dbg}, {14'd0, S_ZERO});
        chk("zero_key_done", {15'd0, timer_done}, 16'd1);

        // 00:02 countdown: ticks after edges 4 and 8
        press(4'd2);
        chk("two_time", t_now, 16'h0002);
        enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            chk($sformatf("run_tick_%0d", i), {15'd0, tick},
                (i == 4 || i == 8) ? 16'd1 : 16'd0);
            if (i == 1) chk("run_running", {15'd0, running}, 16'd1);
            if (i == 4) chk("run_time_1", t_now, 16'h0001);
            if (i == 7) chk("run_done_lo", {15'd0, timer_done}, 16'd0);
            if (i == 8) begin
                chk("run_time_0", t_now, 16'h0000);
                chk("run_done_hi", {15'd0, timer_done}, 16'd1);
                chk("run_running_lo", {15'd0, running}, 16'd0);
                chk("run_state_zero", {14'd0, state_dbg}, {14'd0, S_ZERO});
            end
        end
        enable = 1'b0;
        cyc();

        // borrow 10:00 -> 09:59, with a load attempted while counting
        press(4'd1);
        press(4'd0);
        press(4'd0);
        press(4'd0);
        chk("b_load", t_now, 16'h1000);
        enable = 1'b1;
        cyc();
        digit = 4'd7;
        load  = 1'b1;
        cyc();
        load  = 1'b0;
        chk("load_while_cnt", t_now, 16'h1000);
        cyc();
        cyc();
        chk("borrow_time", t_now, 16'h0959);
        chk("borrow_tick", {15'd0, tick}, 16'd1);
        enable = 1'b0;
        cyc();
        chk("pause_state", {14'd0, state_dbg}, {14'd0, S_ARMED});

        // 00:90 -> 00:89
        clear_pulse();
        press(4'd9);
        press(4'd0);
        chk("s90_load", t_now, 16'h0090);
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) cyc();
        chk("s90_time", t_now, 16'h0089);
        chk("s90_tick", {15'd0, tick}, 16'd1);
        enable = 1'b0;
        cyc();

        // pause two cycles before a tick, hold, resume
        enable = 1'b1;
        cyc();
        cyc();
        enable = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk($sformatf("hold_time_%0d", i), t_now, 16'h0089);
            chk($sformatf("hold_tick_%0d", i), {15'd0, tick}, 16'd0);
        end
        chk("hold_state", {14'd0, state_dbg}, {14'd0, S_ARMED});
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("resume_tick_%0d", i), {15'd0, tick}, (i == 4) ? 16'd1 : 16'd0);
        end
        chk("resume_time", t_now, 16'h0088);

        // clear on the tick edge
        cyc();
        cyc();
        cyc();
        chk("pre_clr_time", t_now, 16'h0088);
        clearn = 1'b0;
        cyc();
        clearn = 1'b1;
        chk("clrtick_time", t_now, 16'h0000);
        chk("clrtick_tick", {15'd0, tick}, 16'd0);
        chk("clrtick_done", {15'd0, timer_done}, 16'd1);
        chk("clrtick_state", {14'd0, state_dbg}, {14'd0, S_ZERO});
        enable = 1'b0;
        cyc();

        // async reset between edges while tick is high
        press(4'd5);
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) cyc();
        chk("ar_pre_time", t_now, 16'h0004);
        chk("ar_pre_tick", {15'd0, tick}, 16'd1);
        #2 resetn = 1'b0;
        #1;
        chk("ar_time", t_now, 16'h0000);
        chk("ar_tick", {15'd0, tick}, 16'd0);
        chk("ar_running", {15'd0, running}, 16'd0);
        chk("ar_done", {15'd0, timer_done}, 16'd1);
        chk("ar_state", {14'd0, state_dbg}, {14'd0, S_ZERO});
        enable = 1'b0;
        cyc();
        resetn = 1'b1;
        cyc();

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
